// File: rtl/avl_arb_pkg.sv
// Shared types and constants for the LPDDR2 Avalon write-port arbiter.
// The AVL_ARB_FIXED_PRIO_EN macro (see avl_arb_pick) selects fixed priority
// instead of round-robin; nothing in this package depends on it.
package avl_arb_pkg;

    // Debug encoding exported on arb_state; the values are visible to software.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        ACK    = 2'd2,
        DECIDE = 2'd3
    } arb_state_t;

    // Requester identities; the ID doubles as the bit index into rq_valid/gnt/rq_ack.
    localparam logic RQ_CAPTURE = 1'b0;   // ADV7611 pixel writer
    localparam logic RQ_PATTERN = 1'b1;   // test-pattern / frame-fill engine

    localparam int BURST_LEN_DEFAULT = 16;

    // One-hot vector for a requester ID.
    function automatic logic [1:0] rq_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/avl_arb_pick.sv
// Combinational two-way winner selection for the write-port arbiter.
// Build option: AVL_ARB_FIXED_PRIO_EN defined -> requester 0 always wins and
// `last` is ignored; undefined (default) -> round-robin, the requester that
// did not own the port last wins a tie.
module avl_arb_pick
    import avl_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] winner
);

`ifdef AVL_ARB_FIXED_PRIO_EN
    // Fixed priority has no use for history; keep the port for a uniform interface.
    logic unused_last;
    assign unused_last = last;

    // Capture path always wins when it has a word pending.
    always_comb begin
        winner = 2'b00;
        if (valid[RQ_CAPTURE]) begin
            winner = rq_onehot(RQ_CAPTURE);
        end else if (valid[RQ_PATTERN]) begin
            winner = rq_onehot(RQ_PATTERN);
        end
    end
`else
    // Single requester wins outright; on a tie the one that was not last wins.
    always_comb begin
        winner = 2'b00;
        if (valid == 2'b11) begin
            winner = rq_onehot(~last);
        end else begin
            winner = valid;
        end
    end
`endif

endmodule

// File: rtl/avl_write_arbiter.sv
// Two-requester arbiter for the single LPDDR2 Avalon-MM write port.
// Requester 0 is the HDMI capture path, requester 1 the pattern/fill engine.
// A grant covers up to BURST_LEN single-beat writes, then the port is
// re-arbitrated. Build option AVL_ARB_FIXED_PRIO_EN (in avl_arb_pick) selects
// fixed priority instead of the default round-robin.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no owner; grant when calibrated and any requester is valid
//   WRITE  | avl_write held with stable address/data until accepted
//   ACK    | rq_ack pulse to the owner; owner advances to its next word
//   DECIDE | continue the burst, or release the port and remember the owner
module avl_write_arbiter
    import avl_arb_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              local_init_done,
    input  logic              avl_waitrequest_n,
    output logic [ADDR_W-1:0] avl_address,
    output logic [DATA_W-1:0] avl_writedata,
    output logic              avl_write,
    output logic              avl_burstbegin,
    input  logic [1:0]        rq_valid,
    input  logic [ADDR_W-1:0] rq_addr0,
    input  logic [ADDR_W-1:0] rq_addr1,
    input  logic [DATA_W-1:0] rq_data0,
    input  logic [DATA_W-1:0] rq_data1,
    output logic [1:0]        rq_ack,
    output logic [1:0]        gnt,
    output logic [1:0]        arb_state
);

    // Burst limit as an 8-bit unsigned value so the word counter never wraps.
    localparam logic [7:0] BURST_LEN_U = 8'(BURST_LEN);

    arb_state_t        state, state_nxt;
    logic              owner, owner_nxt;
    logic              last, last_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [1:0]        gnt_nxt;
    logic [1:0]        ack_nxt;
    logic              write_nxt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [1:0]        pick_win;

    avl_arb_pick u_pick (
        .valid  (rq_valid),
        .last   (last),
        .winner (pick_win)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        write_nxt = avl_write;
        addr_nxt  = avl_address;
        data_nxt  = avl_writedata;
        ack_nxt   = 2'b00;

        case (state)
            IDLE: begin
                write_nxt = 1'b0;
                gnt_nxt   = 2'b00;
                if (local_init_done && (rq_valid != 2'b00)) begin
                    owner_nxt = pick_win[1];
                    gnt_nxt   = pick_win;
                    cnt_nxt   = 8'd0;
                    write_nxt = 1'b1;
                    addr_nxt  = (pick_win[1] == RQ_PATTERN) ? rq_addr1 : rq_addr0;
                    data_nxt  = (pick_win[1] == RQ_PATTERN) ? rq_data1 : rq_data0;
                    state_nxt = WRITE;
                end
            end

            WRITE: begin
                // A started transfer always completes, even if calibration drops.
                if (avl_write && avl_waitrequest_n) begin
                    write_nxt = 1'b0;
                    ack_nxt   = rq_onehot(owner);
                    cnt_nxt   = cnt + 8'd1;
                    state_nxt = ACK;
                end
            end

            ACK: begin
                state_nxt = DECIDE;
            end

            DECIDE: begin
                if (local_init_done && rq_valid[owner] && (cnt < BURST_LEN_U)) begin
                    write_nxt = 1'b1;
                    addr_nxt  = (owner == RQ_PATTERN) ? rq_addr1 : rq_addr0;
                    data_nxt  = (owner == RQ_PATTERN) ? rq_data1 : rq_data0;
                    state_nxt = WRITE;
                end else begin
                    gnt_nxt   = 2'b00;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end

            default: begin
                write_nxt = 1'b0;
                gnt_nxt   = 2'b00;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops avl_write immediately.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state         <= IDLE;
            owner         <= RQ_CAPTURE;
            last          <= RQ_PATTERN;
            cnt           <= 8'd0;
            gnt           <= 2'b00;
            rq_ack        <= 2'b00;
            avl_write     <= 1'b0;
            avl_address   <= '0;
            avl_writedata <= '0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            last          <= last_nxt;
            cnt           <= cnt_nxt;
            gnt           <= gnt_nxt;
            rq_ack        <= ack_nxt;
            avl_write     <= write_nxt;
            avl_address   <= addr_nxt;
            avl_writedata <= data_nxt;
        end
    end

    // Delayed write strobe used to mark the first cycle of each write.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            write_q <= 1'b0;
        end else begin
            write_q <= avl_write;
        end
    end

    assign avl_burstbegin = avl_write & ~write_q;
    assign arb_state      = state;

endmodule

// File: tb/tb_avl_write_arbiter.sv
// Self-checking bench for avl_write_arbiter. Requester models feed words from
// per-requester queues; expected writes are queued at load time and popped when
// the controller side accepts a word.
`timescale 1ns/1ps
module tb_avl_write_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;
    localparam int BLEN   = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    logic              iCLK = 1'b0;
    logic              iRST_n = 1'b1;
    logic              local_init_done = 1'b0;
    logic              avl_waitrequest_n = 1'b1;
    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_write;
    logic              avl_burstbegin;
    logic [1:0]        rq_valid = 2'b00;
    logic [ADDR_W-1:0] rq_addr0 = '0;
    logic [ADDR_W-1:0] rq_addr1 = '0;
    logic [DATA_W-1:0] rq_data0 = '0;
    logic [DATA_W-1:0] rq_data1 = '0;
    logic [1:0]        rq_ack;
    logic [1:0]        gnt;
    logic [1:0]        arb_state;

    word_t rq_q0[$];
    word_t rq_q1[$];
    word_t exp_q0[$];
    word_t exp_q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    avl_write_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BLEN)
    ) dut (
        .iCLK              (iCLK),
        .iRST_n            (iRST_n),
        .local_init_done   (local_init_done),
        .avl_waitrequest_n (avl_waitrequest_n),
        .avl_address       (avl_address),
        .avl_writedata     (avl_writedata),
        .avl_write         (avl_write),
        .avl_burstbegin    (avl_burstbegin),
        .rq_valid          (rq_valid),
        .rq_addr0          (rq_addr0),
        .rq_addr1          (rq_addr1),
        .rq_data0          (rq_data0),
        .rq_data1          (rq_data1),
        .rq_ack            (rq_ack),
        .gnt               (gnt),
        .arb_state         (arb_state)
    );

    always #5 iCLK = ~iCLK;

    // Queue a word for a requester and record it as an expected write.
    task automatic load(input bit id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        word_t w;
        w.addr = a;
        w.data = d;
        if (id) begin
            rq_q1.push_back(w);
            exp_q1.push_back(w);
        end else begin
            rq_q0.push_back(w);
            exp_q0.push_back(w);
        end
    endtask

    task automatic drive_rq();
        rq_valid[0] = (rq_q0.size() != 0);
        rq_valid[1] = (rq_q1.size() != 0);
        rq_addr0    = rq_valid[0] ? rq_q0[0].addr : '0;
        rq_data0    = rq_valid[0] ? rq_q0[0].data : '0;
        rq_addr1    = rq_valid[1] ? rq_q1[0].addr : '0;
        rq_data1    = rq_valid[1] ? rq_q1[0].data : '0;
    endtask

    task automatic clear_queues();
        rq_q0.delete();
        rq_q1.delete();
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Advance to the next falling edge; requesters move on after an ack.
    task automatic step();
        @(negedge iCLK);
        if (rq_ack[0] && rq_q0.size() != 0) void'(rq_q0.pop_front());
        if (rq_ack[1] && rq_q1.size() != 0) void'(rq_q1.pop_front());
        drive_rq();
    endtask

    task automatic do_reset();
        iRST_n            = 1'b0;
        local_init_done   = 1'b1;
        avl_waitrequest_n = 1'b1;
        clear_queues();
        drive_rq();
        repeat (2) @(negedge iCLK);
        iRST_n = 1'b1;
    endtask

    task automatic test_reset();
        bit bad;
        iRST_n = 1'b0;
        local_init_done = 1'b0;
        avl_waitrequest_n = 1'b1;
        clear_queues();
        load(1'b0, 27'h10, 32'h00AA0000);
        load(1'b1, 27'h20, 32'h0000BB00);
        drive_rq();
        repeat (2) @(negedge iCLK);
        n_tests++;
        if ({avl_write, avl_burstbegin, gnt, rq_ack, arb_state} !== 8'h00 ||
            avl_address !== '0 || avl_writedata !== '0) begin
            n_fail++;
            $display("FAIL reset_values: write %b bb %b gnt %b ack %b state %0d addr %h data %h, expected all zero",
                     avl_write, avl_burstbegin, gnt, rq_ack, arb_state, avl_address, avl_writedata);
        end
        iRST_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (avl_write !== 1'b0 || gnt !== 2'b00) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL no_grant_before_init: write %b gnt %b, expected 0 and 00", avl_write, gnt);
        end
        local_init_done = 1'b1;
        step();
        n_tests++;
        if (gnt !== 2'b01 || avl_write !== 1'b1 || avl_burstbegin !== 1'b1 ||
            avl_address !== 27'h10 || arb_state !== 2'd1) begin
            n_fail++;
            $display("FAIL first_grant: gnt %b write %b bb %b addr %h state %0d, expected 01 1 1 010 1",
                     gnt, avl_write, avl_burstbegin, avl_address, arb_state);
        end
    endtask

    task automatic test_burst_limit();
        int acc = 0, acks = 0, grants = 0, bb = 0, last_acc = 0;
        bit ack_due = 0;
        logic [1:0] ack_exp = 2'b00;
        logic [1:0] prev_gnt = 2'b00;
        word_t e;
        do_reset();
        for (int i = 0; i < 20; i++) load(1'b1, 27'(32'h100 + i), 32'h00FF0000 + 32'(i));
        drive_rq();
        for (int c = 0; c < 100; c++) begin
            step();
            if (rq_ack != 2'b00) acks++;
            if (ack_due) begin
                n_tests++;
                if (rq_ack !== ack_exp) begin
                    n_fail++;
                    $display("FAIL burst_ack: ack %b, expected %b", rq_ack, ack_exp);
                end
                ack_due = 0;
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) grants++;
            prev_gnt = gnt;
            if (avl_burstbegin) bb++;
            if (avl_write && avl_waitrequest_n) begin
                n_tests++;
                e = (exp_q1.size() != 0) ? exp_q1.pop_front() : '0;
                if (gnt !== 2'b10 || avl_address !== e.addr || avl_writedata !== e.data) begin
                    n_fail++;
                    $display("FAIL burst_word: gnt %b addr %h data %h, expected 10 %h %h",
                             gnt, avl_address, avl_writedata, e.addr, e.data);
                end
                if (acc > 0) begin
                    n_tests++;
                    if (c - last_acc != ((acc == BLEN) ? 4 : 3)) begin
                        n_fail++;
                        $display("FAIL burst_spacing: word %0d gap %0d, expected %0d",
                                 acc, c - last_acc, (acc == BLEN) ? 4 : 3);
                    end
                end
                last_acc = c;
                acc++;
                ack_exp = gnt;
                ack_due = 1;
            end
        end
        n_tests++;
        if (acc != 20 || acks != 20 || bb != 20 || grants != 2) begin
            n_fail++;
            $display("FAIL burst_totals: writes %0d acks %0d burstbegins %0d grants %0d, expected 20 20 20 2",
                     acc, acks, bb, grants);
        end
    endtask

    task automatic test_arbitration();
        int order[$];
        int exp_order[4];
        logic [1:0] prev_gnt = 2'b00;
        word_t e;
        bit ok;
`ifdef AVL_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        do_reset();
        for (int i = 0; i < 32; i++) begin
            load(1'b0, 27'(32'h1000 + i), 32'h00000100 + 32'(i));
            load(1'b1, 27'(32'h2000 + i), 32'h00020000 + 32'(i));
        end
        drive_rq();
        for (int c = 0; c < 260; c++) begin
            step();
            if (gnt != 2'b00 && prev_gnt == 2'b00) order.push_back(gnt[1] ? 1 : 0);
            prev_gnt = gnt;
            if (avl_write && avl_waitrequest_n) begin
                n_tests++;
                ok = 1;
                e  = '0;
                if (gnt == 2'b01 && exp_q0.size() != 0) e = exp_q0.pop_front();
                else if (gnt == 2'b10 && exp_q1.size() != 0) e = exp_q1.pop_front();
                else ok = 0;
                if (!ok || avl_address !== e.addr || avl_writedata !== e.data) begin
                    n_fail++;
                    $display("FAIL arb_word: gnt %b addr %h data %h, expected addr %h data %h",
                             gnt, avl_address, avl_writedata, e.addr, e.data);
                end
            end
        end
        n_tests++;
        if (order.size() != 4 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL arb_grants: %0d grants, %0d/%0d words unwritten, expected 4 grants 0/0",
                     order.size(), exp_q0.size(), exp_q1.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) begin
                n_tests++;
                if (order[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL arb_order: grant %0d went to %0d, expected %0d", i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit found = 0;
        do_reset();
        avl_waitrequest_n = 1'b0;
        load(1'b0, 27'h3ABC, 32'h00123456);
        drive_rq();
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (avl_write) found = 1;
        end
        n_tests++;
        if (!found || avl_burstbegin !== 1'b1 || avl_address !== 27'h3ABC || avl_writedata !== 32'h00123456) begin
            n_fail++;
            $display("FAIL stall_start: seen %0d bb %b addr %h data %h, expected 1 1 3abc 00123456",
                     found, avl_burstbegin, avl_address, avl_writedata);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            n_tests++;
            if (avl_write !== 1'b1 || avl_burstbegin !== 1'b0 || rq_ack !== 2'b00 || arb_state !== 2'd1 ||
                avl_address !== 27'h3ABC || avl_writedata !== 32'h00123456) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d write %b bb %b ack %b state %0d addr %h data %h",
                         k, avl_write, avl_burstbegin, rq_ack, arb_state, avl_address, avl_writedata);
            end
        end
        avl_waitrequest_n = 1'b1;
        step();
        n_tests++;
        if (rq_ack !== 2'b01 || arb_state !== 2'd2 || avl_write !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ack: ack %b state %0d write %b, expected 01 2 0", rq_ack, arb_state, avl_write);
        end
        step();
        n_tests++;
        if (rq_ack !== 2'b00 || arb_state !== 2'd3) begin
            n_fail++;
            $display("FAIL stall_pulse: ack %b state %0d, expected 00 3", rq_ack, arb_state);
        end
        step();
        n_tests++;
        if (gnt !== 2'b00 || arb_state !== 2'd0) begin
            n_fail++;
            $display("FAIL stall_release: gnt %b state %0d, expected 00 0", gnt, arb_state);
        end
    endtask

    task automatic test_init_drop();
        bit found = 0;
        int writes = 0, acks = 0;
        word_t e;
        do_reset();
        avl_waitrequest_n = 1'b0;
        for (int i = 0; i < 5; i++) load(1'b1, 27'(32'h500 + i), 32'h0000FF00 + 32'(i));
        drive_rq();
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (avl_write) found = 1;
        end
        local_init_done = 1'b0;
        step();
        step();
        n_tests++;
        if (!found || avl_write !== 1'b1 || arb_state !== 2'd1) begin
            n_fail++;
            $display("FAIL init_drop_hold: seen %0d write %b state %0d, expected 1 1 1", found, avl_write, arb_state);
        end
        avl_waitrequest_n = 1'b1;
        if (avl_write && avl_waitrequest_n) begin
            n_tests++;
            e = (exp_q1.size() != 0) ? exp_q1.pop_front() : '0;
            if (gnt !== 2'b10 || avl_address !== e.addr || avl_writedata !== e.data) begin
                n_fail++;
                $display("FAIL init_drop_word: gnt %b addr %h data %h, expected 10 %h %h",
                         gnt, avl_address, avl_writedata, e.addr, e.data);
            end
        end
        for (int c = 0; c < 20; c++) begin
            step();
            if (rq_ack != 2'b00) acks++;
            if (avl_write) writes++;
        end
        n_tests++;
        if (acks != 1 || writes != 0 || gnt !== 2'b00 || arb_state !== 2'd0) begin
            n_fail++;
            $display("FAIL init_drop_release: acks %0d writes %0d gnt %b state %0d, expected 1 0 00 0",
                     acks, writes, gnt, arb_state);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int first = -1;
        logic [1:0] prev_gnt = 2'b00;
        do_reset();
        load(1'b0, 27'h40, 32'h00000040);
        for (int i = 0; i < 4; i++) load(1'b1, 27'(32'h50 + i), 32'h00500000 + 32'(i));
        drive_rq();
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            if (gnt != 2'b00 && prev_gnt == 2'b00 && first < 0) first = gnt[1] ? 1 : 0;
            prev_gnt = gnt;
            if (gnt == 2'b10 && avl_write) found = 1;
        end
        n_tests++;
        if (!found || first != 0) begin
            n_fail++;
            $display("FAIL mid_setup: req1 writing %0d first owner %0d, expected 1 0", found, first);
        end
        avl_waitrequest_n = 1'b0;
        #2;
        iRST_n = 1'b0;
        #1;
        n_tests++;
        if (avl_write !== 1'b0 || gnt !== 2'b00 || arb_state !== 2'd0 || avl_burstbegin !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: write %b gnt %b state %0d bb %b, expected 0 00 0 0",
                     avl_write, gnt, arb_state, avl_burstbegin);
        end
        clear_queues();
        drive_rq();
        repeat (2) @(negedge iCLK);
        iRST_n = 1'b1;
        avl_waitrequest_n = 1'b1;
        load(1'b0, 27'h60, 32'h00000060);
        load(1'b1, 27'h70, 32'h00000070);
        drive_rq();
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (gnt != 2'b00) found = 1;
        end
        n_tests++;
        if (gnt !== 2'b01 || avl_address !== 27'h60) begin
            n_fail++;
            $display("FAIL mid_regrant: gnt %b addr %h, expected 01 060", gnt, avl_address);
        end
    endtask

    initial begin
        test_reset();
        test_burst_limit();
        test_arbitration();
        test_stall();
        test_init_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
